// File: rtl/ysyx_ifu_pkg.sv
// Shared definitions for the fetch-side read channel FSMs (IFU, LSU read path).
package ysyx_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ysyx_ifu_reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_ifu_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (we) q <= d;
  end

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding AR/R read, registered handoff to decode,
// redirects flush the wrong-path fetch.
//
// state  | meaning
// S_IDLE | post-reset, picks the first fetch address
// S_AR   | read address presented, waiting for arready
// S_R    | waiting for read data (dropped when a redirect is pending)
// S_OUT  | instruction held for decode until out_ready or redirect
module ysyx_ifu
  import ysyx_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_arvalid,
  output logic [31:0] imem_araddr,
  input  logic        imem_arready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  output logic        imem_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  ifu_state_e  state;
  logic        drop;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] pc;
  logic [31:0] ar_addr;
  logic [31:0] redir_tgt;
  logic        accept;
  logic        ar_load;
  logic [31:0] ar_next;

  assign redir_tgt   = align_word(redirect_pc);
  assign accept      = (state == S_R) && imem_rvalid && !drop && !redirect_valid;
  assign imem_araddr = ar_addr;

  // Every transition into S_AR goes through ar_load; pc always tracks the address being fetched.
  always_comb begin
    ar_load = 1'b0;
    ar_next = pc;
    case (state)
      S_IDLE: begin
        ar_load = 1'b1;
        ar_next = redirect_valid ? redir_tgt : pc;
      end
      S_R: begin
        if (imem_rvalid && !accept) begin
          ar_load = 1'b1;
          ar_next = redirect_valid ? redir_tgt : pend_pc;
        end
      end
      S_OUT: begin
        if (out_ready || redirect_valid) begin
          ar_load = 1'b1;
          ar_next = redirect_valid ? redir_tgt : pc + PC_STEP;
        end
      end
      default: ;
    endcase
  end

  ysyx_ifu_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .we(ar_load), .d(ar_next), .q(pc)
  );

  ysyx_ifu_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pend_pc (
    .clk(clk), .rst(rst), .we(redirect_valid), .d(redir_tgt), .q(pend_pc)
  );

  ysyx_ifu_reg #(.WIDTH(32), .RESET_VAL(NOP_INST)) u_out_inst (
    .clk(clk), .rst(rst), .we(accept), .d(imem_rdata), .q(out_inst)
  );

  ysyx_ifu_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_out_pc (
    .clk(clk), .rst(rst), .we(accept), .d(pc), .q(out_pc)
  );

  ysyx_ifu_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_out_fault (
    .clk(clk), .rst(rst), .we(accept), .d(imem_rresp != RESP_OKAY), .q(out_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      drop         <= 1'b0;
      pend_valid   <= 1'b0;
      ar_addr      <= RESET_PC;
      imem_arvalid <= 1'b0;
      imem_rready  <= 1'b0;
      out_valid    <= 1'b0;
    end else if (ar_load) begin
      state        <= S_AR;
      drop         <= 1'b0;
      pend_valid   <= 1'b0;
      ar_addr      <= ar_next;
      imem_arvalid <= 1'b1;
      imem_rready  <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          // arvalid is never withdrawn; a redirect here only marks the read for discard.
          if (redirect_valid) begin
            pend_valid <= 1'b1;
            drop       <= 1'b1;
          end
          if (imem_arready) begin
            imem_arvalid <= 1'b0;
            imem_rready  <= 1'b1;
            state        <= S_R;
          end
        end
        S_R: begin
          if (accept) begin
            imem_rready <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_OUT;
          end else if (redirect_valid) begin
            pend_valid <= 1'b1;
            drop       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed bench for ysyx_ifu: reset, sequential fetch, backpressure, redirects, faults, wrap.
module tb_ysyx_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_ifu dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(imem_arready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
    .imem_rready(imem_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".arvalid"}, 32'(imem_arvalid), 32'd0);
    check({tag, ".rready"},  32'(imem_rready),  32'd0);
    check({tag, ".ovalid"},  32'(out_valid),    32'd0);
    check({tag, ".oinst"},   out_inst,          32'h0000_0013);
    check({tag, ".opc"},     out_pc,            32'h8000_0000);
    check({tag, ".ofault"},  32'(out_fault),    32'd0);
  endtask

  // Starts in S_AR, zero-wait AR and R, ends in S_OUT.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input logic fault);
    check({tag, ".arvalid"}, 32'(imem_arvalid), 32'd1);
    check({tag, ".araddr"},  imem_araddr,       addr);
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    check({tag, ".rready"},  32'(imem_rready),  32'd1);
    check({tag, ".ar_done"}, 32'(imem_arvalid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    imem_rresp  = resp;
    tick();
    imem_rvalid = 1'b0;
    imem_rresp  = 2'b00;
    check({tag, ".ovalid"}, 32'(out_valid), 32'd1);
    check({tag, ".oinst"},  out_inst,       data);
    check({tag, ".opc"},    out_pc,         addr);
    check({tag, ".ofault"}, 32'(out_fault), 32'(fault));
  endtask

  task automatic accept_out(input string tag, input logic [31:0] next_addr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".ovalid_drop"}, 32'(out_valid),    32'd0);
    check({tag, ".next_arvalid"}, 32'(imem_arvalid), 32'd1);
    check({tag, ".next_araddr"}, imem_araddr,       next_addr);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_arready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    imem_rresp = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // 1: first fetch after reset release
    rst = 1'b0;
    tick();
    do_fetch("t1", 32'h8000_0000, 32'h0010_0093, 2'b00, 1'b0);
    accept_out("t1", 32'h8000_0004);

    // 2: backpressure holds the output and issues no new read
    do_fetch("t2", 32'h8000_0004, 32'h0020_0113, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2.hold_valid", 32'(out_valid), 32'd1);
      check("t2.hold_inst", out_inst, 32'h0020_0113);
      check("t2.hold_pc", out_pc, 32'h8000_0004);
      check("t2.hold_arvalid", 32'(imem_arvalid), 32'd0);
    end
    accept_out("t2", 32'h8000_0008);

    // 3: redirect coincident with read data in S_R
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    check("t3.ovalid", 32'(out_valid), 32'd0);
    check("t3.oinst_kept", out_inst, 32'h0020_0113);
    check("t3.arvalid", 32'(imem_arvalid), 32'd1);
    check("t3.araddr", imem_araddr, 32'h8000_0100);
    do_fetch("t3b", 32'h8000_0100, 32'h0030_0193, 2'b00, 1'b0);
    accept_out("t3b", 32'h8000_0104);

    // 4: two redirects while AR is stalled; the later one wins, low bits masked
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    check("t4.araddr_c1", imem_araddr, 32'h8000_0104);
    check("t4.arvalid_c1", 32'(imem_arvalid), 32'd1);
    tick();
    check("t4.araddr_c2", imem_araddr, 32'h8000_0104);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0303;
    tick();
    redirect_valid = 1'b0;
    check("t4.araddr_c3", imem_araddr, 32'h8000_0104);
    check("t4.arvalid_c3", 32'(imem_arvalid), 32'd1);
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    check("t4.rready", 32'(imem_rready), 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    check("t4.ovalid", 32'(out_valid), 32'd0);
    check("t4.oinst_kept", out_inst, 32'h0030_0193);
    check("t4.araddr_tgt", imem_araddr, 32'h8000_0300);
    do_fetch("t4b", 32'h8000_0300, 32'h0040_0213, 2'b00, 1'b0);
    accept_out("t4b", 32'h8000_0304);

    // 5: access fault is forwarded, then cleared by the next OK fetch
    do_fetch("t5f", 32'h8000_0304, 32'h0000_0000, 2'b10, 1'b1);
    accept_out("t5f", 32'h8000_0308);
    do_fetch("t5ok", 32'h8000_0308, 32'h0050_0293, 2'b00, 1'b0);

    // 6: redirect together with out_ready, then PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    check("t6.ovalid", 32'(out_valid), 32'd0);
    check("t6.araddr", imem_araddr, 32'hFFFF_FFFC);
    do_fetch("t6w", 32'hFFFF_FFFC, 32'h0060_0313, 2'b00, 1'b0);
    accept_out("t6w", 32'h0000_0000);
    do_fetch("t6z", 32'h0000_0000, 32'h0070_0393, 2'b00, 1'b0);

    // flush in S_OUT without out_ready
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    check("t6.flush_ovalid", 32'(out_valid), 32'd0);
    check("t6.flush_araddr", imem_araddr, 32'h8000_0400);

    // reset while in S_R
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    check("t6.in_r", 32'(imem_rready), 32'd1);
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_1111;
    tick();
    check_reset_outputs("t6.rst");
    rst = 1'b0;
    imem_rvalid = 1'b0;
    tick();
    check("t6.post_arvalid", 32'(imem_arvalid), 32'd1);
    check("t6.post_araddr", imem_araddr, 32'h8000_0000);
    check("t6.post_ovalid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
